hamming_secded_decoder: RTL and testbench
=========================================

// Module: hamming_secded_decoder
// PURPOSE
//  Parametrised, pipelined Hamming SEC-DED decoder; the receive-side companion of the (7,4) code generator.
//  Accepts DATA_BITS-wide data protected by Hamming parity plus an optional overall parity bit.
//  Returns corrected data, per-word error flags and saturating error counters.
//  Streams over a valid/ready handshake between the link/memory read path and the consumer.
// PARAMETERS
//  DATA_BITS   4   payload width; PARITY_BITS = smallest r with 2^r >= DATA_BITS+r+1 (localparam)
//  EXT_PARITY  1   1: overall parity bit present (SEC-DED); 0: SEC only, ERR_DOUBLE tied 0
//  CNT_BITS    16  width of each error counter
//  (localparam CODE_BITS = DATA_BITS + PARITY_BITS + EXT_PARITY; default 8)
// PORTS
//  CLK         in   1              single clock, rising edge
//  RST         in   1              synchronous, active-high reset
//  IN_VALID    in   1              CODE_IN valid
//  IN_READY    out  1              decoder can accept a word this cycle
//  CODE_IN     in   CODE_BITS      bit i = Hamming position i+1; parity at positions 1,2,4,..; overall parity at MSB
//  OUT_VALID   out  1              DATA_OUT/flags valid
//  OUT_READY   in   1              consumer accepts output
//  DATA_OUT    out  DATA_BITS      corrected payload; data positions in ascending order, LSB first
//  ERR_SINGLE  out  1              single-bit error detected and corrected (includes overall-parity-bit error)
//  ERR_DOUBLE  out  1              uncorrectable double error; DATA_OUT = uncorrected payload
//  SYNDROME    out  PARITY_BITS    raw syndrome of the word on DATA_OUT
//  CNT_CLR     in   1              synchronous clear of both counters
//  SEC_CNT     out  CNT_BITS       accepted words with ERR_SINGLE, saturating
//  DED_CNT     out  CNT_BITS       accepted words with ERR_DOUBLE, saturating
// BEHAVIOUR
//  - Reset: all stage valids 0; OUT_VALID=0; DATA_OUT, flags, SYNDROME and counters = 0. IN_READY=1 the cycle after RST falls.
//  - Reset mid-stream discards every in-flight word. No partial output after RST.
//  - Two-stage elastic pipeline; latency 2 cycles from input accept to OUT_VALID; full throughput 1 word/cycle.
//    S1: capture CODE_IN, syndrome s = XOR of positions whose index has bit k set, overall parity p = XOR of all bits.
//    S2: correct, classify, drive outputs.
//  - Handshake: a transfer occurs when VALID&&READY. A stage loads when it is empty or its word leaves the same cycle.
//    IN_READY = !s1_v || (!s2_v || OUT_READY); no combinational path from IN_VALID to IN_READY.
//  - Output stability: while OUT_VALID && !OUT_READY, all outputs hold stable and the pipeline stalls.
//  - Classification with EXT_PARITY=1:
//    s=0, p=0 -> clean
//    s!=0, p=1 -> single; flip position s
//    s=0, p=1 -> single in overall-parity bit; data untouched
//    s!=0, p=0 -> double; no flip
//  - Classification with EXT_PARITY=0: s!=0 -> single, flip position s.
//  - s > DATA_BITS+PARITY_BITS (impossible position) -> ERR_DOUBLE=1, no flip.
//  - Counters: increment on output transfer with the matching flag; hold at 2^CNT_BITS-1.
//    CNT_CLR in the same cycle as an increment -> counter = 0 (clear wins).
// STRUCTURE
//  - Package hamming_pkg: function parity_bits(data_bits), function is_pow2(pos),
//    data-position map function, and the shared enum {CLEAN, SINGLE, DOUBLE}.
//  - Sub-module hamming_syndrome (combinational; CODE_IN -> syndrome, overall parity), reused by later encoder revisions.
//  - Remaining logic stays in this module: pipeline registers, handshake, correction and counters.
// TESTING
//  - Defaults. CODE_IN=8'h55 (DATA 4'b1011) -> 2 cycles later DATA_OUT=4'b1011, flags 0, SYNDROME=0.
//  - CODE_IN=8'h51 (bit 2 flipped) -> DATA_OUT=4'b1011, ERR_SINGLE=1, SYNDROME=3, SEC_CNT=1.
//  - CODE_IN=8'h56 (bits 0,1 flipped) -> ERR_DOUBLE=1, SYNDROME=3, DATA_OUT=4'b1011 (uncorrected payload), DED_CNT=1.
//  - CODE_IN=8'hD5 (overall parity bit flipped) -> DATA_OUT=4'b1011, ERR_SINGLE=1, SYNDROME=0.
//  - Back-pressure.
//    Stream 4 words with OUT_READY=0 -> IN_READY drops after 2 words accepted and outputs hold.
//    Then OUT_READY=1 -> all 4 words emerge in order, with no loss or duplicates.
//  - Counters and reset.
//    CNT_BITS=2, 5 single errors -> SEC_CNT=3. Then CNT_CLR together with a single error -> SEC_CNT=0.
//    RST with 2 words in flight -> OUT_VALID=0 next cycle and nothing is emitted.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: parity-width sizing, position classification,
// data-position mapping and the per-word error class.
package hamming_pkg;

  typedef enum logic [1:0] {
    CLEAN,
    SINGLE,
    DOUBLE
  } err_class_e;

  // Smallest r with 2^r >= data_bits + r + 1.
  function automatic int unsigned parity_bits(input int unsigned data_bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (r == 0 && (32'd1 << i) >= data_bits + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // 1-based Hamming position of payload bit idx (payload fills non-power-of-two slots).
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned p = 1; p < 256; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of a received codeword.
// Bit i of code is Hamming position i+1; bits at or above HAM_BITS only feed the overall parity.
module hamming_syndrome #(
  parameter int unsigned HAM_BITS    = 7,
  parameter int unsigned PARITY_BITS = 3,
  parameter int unsigned CODE_BITS   = 8
) (
  input  logic [CODE_BITS-1:0]   code,
  output logic [PARITY_BITS-1:0] syndrome,
  output logic                   parity
);

  always_comb begin
    syndrome = '0;
    for (int unsigned k = 0; k < PARITY_BITS; k++) begin
      for (int unsigned i = 0; i < HAM_BITS; i++) begin
        if ((((i + 1) >> k) & 1) != 0) syndrome[k] = syndrome[k] ^ code[i];
      end
    end
    parity = ^code;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage elastic Hamming SEC-DED decoder with saturating error counters.
// S1 holds the raw codeword; S2 holds the corrected payload, class and syndrome.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_BITS   = 4,
  parameter  int unsigned EXT_PARITY  = 1,
  parameter  int unsigned CNT_BITS    = 16,
  localparam int unsigned PARITY_BITS = parity_bits(DATA_BITS),
  localparam int unsigned HAM_BITS    = DATA_BITS + PARITY_BITS,
  localparam int unsigned CODE_BITS   = HAM_BITS + EXT_PARITY
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [CODE_BITS-1:0]   CODE_IN,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [DATA_BITS-1:0]   DATA_OUT,
  output logic                   ERR_SINGLE,
  output logic                   ERR_DOUBLE,
  output logic [PARITY_BITS-1:0] SYNDROME,
  input  logic                   CNT_CLR,
  output logic [CNT_BITS-1:0]    SEC_CNT,
  output logic [CNT_BITS-1:0]    DED_CNT
);

  logic                   s1_v;
  logic [CODE_BITS-1:0]   s1_code;
  logic                   s2_v;
  logic [DATA_BITS-1:0]   s2_data;
  err_class_e             s2_cls;
  logic [PARITY_BITS-1:0] s2_syn;

  logic [PARITY_BITS-1:0] syn;
  logic                   par;
  logic                   pos_ok;
  logic                   flip;
  err_class_e             cls;
  logic [HAM_BITS-1:0]    corrected;
  logic [DATA_BITS-1:0]   data_fix;
  logic                   s1_ready;
  logic                   s2_ready;
  logic                   out_xfer;

  assign s2_ready = !s2_v || OUT_READY;
  assign s1_ready = !s1_v || s2_ready;
  assign IN_READY = !RST && s1_ready;
  assign out_xfer = s2_v && OUT_READY;

  hamming_syndrome #(
    .HAM_BITS   (HAM_BITS),
    .PARITY_BITS(PARITY_BITS),
    .CODE_BITS  (CODE_BITS)
  ) u_syndrome (
    .code    (s1_code),
    .syndrome(syn),
    .parity  (par)
  );

  // Without the overall parity bit an out-of-range syndrome is still reported, but nothing is flipped.
  always_comb begin
    cls    = CLEAN;
    flip   = 1'b0;
    pos_ok = (syn != '0) && (32'(syn) <= HAM_BITS);
    if (EXT_PARITY != 0) begin
      if (syn == '0) begin
        cls = par ? SINGLE : CLEAN;
      end else if (par && pos_ok) begin
        cls  = SINGLE;
        flip = 1'b1;
      end else begin
        cls = DOUBLE;
      end
    end else if (syn != '0) begin
      cls  = SINGLE;
      flip = pos_ok;
    end
    corrected = s1_code[HAM_BITS-1:0];
    for (int unsigned i = 0; i < HAM_BITS; i++) begin
      if (flip && 32'(syn) == i + 1) corrected[i] = !corrected[i];
    end
  end

  for (genvar j = 0; j < DATA_BITS; j++) begin : g_data
    localparam int unsigned POS = data_pos(j);
    assign data_fix[j] = corrected[POS-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v    <= 1'b0;
      s1_code <= '0;
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_cls  <= CLEAN;
      s2_syn  <= '0;
    end else begin
      if (s1_ready) begin
        s1_v <= IN_VALID;
        if (IN_VALID) s1_code <= CODE_IN;
      end
      if (s2_ready) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_data <= data_fix;
          s2_cls  <= cls;
          s2_syn  <= syn;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      SEC_CNT <= '0;
      DED_CNT <= '0;
    end else if (out_xfer) begin
      if (s2_cls == SINGLE && SEC_CNT != '1) SEC_CNT <= SEC_CNT + 1'b1;
      if (s2_cls == DOUBLE && DED_CNT != '1) DED_CNT <= DED_CNT + 1'b1;
    end
  end

  assign OUT_VALID  = s2_v;
  assign DATA_OUT   = s2_data;
  assign ERR_SINGLE = (s2_cls == SINGLE);
  assign ERR_DOUBLE = (s2_cls == DOUBLE);
  assign SYNDROME   = s2_syn;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder: default instance plus a CNT_BITS=2 instance on the same stream.
module tb_hamming_secded_decoder;

  typedef struct packed {
    logic [3:0] d;
    logic       es;
    logic       ed;
    logic [2:0] syn;
  } out_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  code_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  data_out;
  logic        err_single;
  logic        err_double;
  logic [2:0]  syndrome;
  logic        cnt_clr;
  logic [15:0] sec_cnt;
  logic [15:0] ded_cnt;

  logic        c_in_ready;
  logic        c_out_valid;
  logic [3:0]  c_data_out;
  logic        c_err_single;
  logic        c_err_double;
  logic [2:0]  c_syndrome;
  logic        c_cnt_clr;
  logic [1:0]  c_sec_cnt;
  logic [1:0]  c_ded_cnt;

  int   checks;
  int   errors;
  int   acc_cnt;
  out_t got_q[$];

  hamming_secded_decoder dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .CODE_IN(code_in),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .DATA_OUT(data_out),
    .ERR_SINGLE(err_single), .ERR_DOUBLE(err_double), .SYNDROME(syndrome),
    .CNT_CLR(cnt_clr), .SEC_CNT(sec_cnt), .DED_CNT(ded_cnt)
  );

  hamming_secded_decoder #(.DATA_BITS(4), .EXT_PARITY(1), .CNT_BITS(2)) dut_c (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(c_in_ready), .CODE_IN(code_in),
    .OUT_VALID(c_out_valid), .OUT_READY(out_ready), .DATA_OUT(c_data_out),
    .ERR_SINGLE(c_err_single), .ERR_DOUBLE(c_err_double), .SYNDROME(c_syndrome),
    .CNT_CLR(c_cnt_clr), .SEC_CNT(c_sec_cnt), .DED_CNT(c_ded_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back({data_out, err_single, err_double, syndrome});
    if (!rst && in_valid && in_ready) acc_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [7:0] c, output bit ok);
    ok = 1'b0;
    code_in = c;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, output bit ok);
    for (int i = 0; i < 200 && got_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; code_in = '0; out_ready = 1'b1; cnt_clr = 1'b0; c_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, data_out, err_single, err_double, syndrome} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0", {out_valid, data_out, err_single, err_double, syndrome});
    end
    checks++;
    if ({sec_cnt, ded_cnt} !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %h exp 0", {sec_cnt, ded_cnt});
    end
    checks++;
    if ({c_out_valid, c_data_out, c_err_single, c_err_double, c_syndrome, c_sec_cnt, c_ded_cnt} !== 14'b0) begin
      errors++; $display("FAIL reset_small_dut got %b exp 0",
                         {c_out_valid, c_data_out, c_err_single, c_err_double, c_syndrome, c_sec_cnt, c_ded_cnt});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, c_in_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_in_ready got %b exp 11", {in_ready, c_in_ready});
    end
  endtask

  task automatic test_clean;
    bit   ok;
    out_t o;
    push_word(8'h55, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_accept got 0 exp 1"); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_latency1 got %b exp 0", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_latency2 got %b exp 1", out_valid); end
    wait_out(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL clean_timeout got 0 words exp 1");
    end else begin
      o = got_q.pop_front();
      if (o !== {4'b1011, 1'b0, 1'b0, 3'd0}) begin
        errors++; $display("FAIL clean_word got %b exp %b", o, {4'b1011, 1'b0, 1'b0, 3'd0});
      end
    end
  endtask

  task automatic test_single;
    bit         ok;
    out_t       o;
    logic [7:0] codes[4];
    out_t       exp[4];
    codes[0] = 8'h51; exp[0] = {4'b1011, 1'b1, 1'b0, 3'd3};
    codes[1] = 8'h13; exp[1] = {4'b0110, 1'b1, 1'b0, 3'd6};
    codes[2] = 8'h15; exp[2] = {4'b1011, 1'b1, 1'b0, 3'd7};
    codes[3] = 8'hD5; exp[3] = {4'b1011, 1'b1, 1'b0, 3'd0};
    for (int i = 0; i < 4; i++) begin
      push_word(codes[i], ok);
      wait_out(1, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL single_timeout code %h", codes[i]);
      end else begin
        o = got_q.pop_front();
        if (o !== exp[i]) begin
          errors++; $display("FAIL single_word code %h got %b exp %b", codes[i], o, exp[i]);
        end
      end
    end
    checks++;
    if ({sec_cnt, ded_cnt} !== {16'd4, 16'd0}) begin
      errors++; $display("FAIL single_counters got %0d/%0d exp 4/0", sec_cnt, ded_cnt);
    end
  endtask

  task automatic test_double;
    bit         ok;
    out_t       o;
    logic [7:0] codes[2];
    out_t       exp[2];
    codes[0] = 8'h56; exp[0] = {4'b1011, 1'b0, 1'b1, 3'd3};
    codes[1] = 8'h41; exp[1] = {4'b1000, 1'b0, 1'b1, 3'd6};
    for (int i = 0; i < 2; i++) begin
      push_word(codes[i], ok);
      wait_out(1, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL double_timeout code %h", codes[i]);
      end else begin
        o = got_q.pop_front();
        if (o !== exp[i]) begin
          errors++; $display("FAIL double_word code %h got %b exp %b", codes[i], o, exp[i]);
        end
      end
    end
    checks++;
    if ({sec_cnt, ded_cnt} !== {16'd4, 16'd2}) begin
      errors++; $display("FAIL double_counters got %0d/%0d exp 4/2", sec_cnt, ded_cnt);
    end
  endtask

  task automatic test_back_pressure;
    bit   ok;
    int   acc0;
    out_t o;
    out_t exp[4];
    exp[0] = {4'b1011, 1'b0, 1'b0, 3'd0};
    exp[1] = {4'b0110, 1'b0, 1'b0, 3'd0};
    exp[2] = {4'b0110, 1'b1, 1'b0, 3'd6};
    exp[3] = {4'b1000, 1'b0, 1'b1, 3'd6};
    got_q.delete();
    out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        bit ok2;
        push_word(8'h55, ok2);
        push_word(8'h33, ok2);
        push_word(8'h13, ok2);
        push_word(8'h41, ok2);
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (acc_cnt - acc0 != 2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall got accepted=%0d in_ready=%b exp 2/0", acc_cnt - acc0, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, data_out, err_single, err_double, syndrome} !== {1'b1, exp[0]}) begin
      errors++; $display("FAIL bp_hold got %b exp %b", {out_valid, data_out, err_single, err_double, syndrome},
                         {1'b1, exp[0]});
    end
    out_ready = 1'b1;
    wait_out(4, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_timeout got %0d words exp 4", got_q.size());
    end
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      o = got_q.pop_front();
      checks++;
      if (o !== exp[i]) begin
        errors++; $display("FAIL bp_order idx %0d got %b exp %b", i, o, exp[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 0 || acc_cnt - acc0 != 4) begin
      errors++; $display("FAIL bp_extra got extra=%0d accepted=%0d exp 0/4", got_q.size(), acc_cnt - acc0);
    end
    checks++;
    if ({sec_cnt, ded_cnt} !== {16'd5, 16'd3}) begin
      errors++; $display("FAIL bp_counters got %0d/%0d exp 5/3", sec_cnt, ded_cnt);
    end
  endtask

  task automatic test_counters;
    bit ok;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'h51, ok);
    wait_out(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cnt_timeout got %0d words exp 5", got_q.size()); end
    checks++;
    if ({c_sec_cnt, c_ded_cnt, sec_cnt} !== {2'd3, 2'd0, 16'd5}) begin
      errors++; $display("FAIL cnt_saturate got small=%0d/%0d wide=%0d exp 3/0/5", c_sec_cnt, c_ded_cnt, sec_cnt);
    end
    push_word(8'h51, ok);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL cnt_clr_wait got %b exp 1", out_valid); end
    cnt_clr = 1'b1;
    c_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    c_cnt_clr = 1'b0;
    checks++;
    if ({c_sec_cnt, sec_cnt, out_valid} !== {2'd0, 16'd0, 1'b0}) begin
      errors++; $display("FAIL cnt_clr_wins got small=%0d wide=%0d ov=%b exp 0/0/0", c_sec_cnt, sec_cnt, out_valid);
    end
    push_word(8'h51, ok);
    wait_out(7, ok);
    checks++;
    if ({c_sec_cnt, sec_cnt} !== {2'd1, 16'd1}) begin
      errors++; $display("FAIL cnt_after_clr got small=%0d wide=%0d exp 1/1", c_sec_cnt, sec_cnt);
    end
    got_q.delete();
  endtask

  task automatic test_reset_inflight;
    bit ok;
    got_q.delete();
    out_ready = 1'b0;
    push_word(8'h55, ok);
    push_word(8'h33, ok);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flight_valid got %b exp 0", out_valid); end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 0 || out_valid !== 1'b0 || sec_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_flight_emit got words=%0d ov=%b sec=%0d exp 0/0/0", got_q.size(), out_valid, sec_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    acc_cnt = 0;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_back_pressure();
    test_counters();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
